multdiv_seq: RTL
================

MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 Port: data_operandA  input  32  multiplicand or dividend, two's complement.
REQ-005 Port: data_operandB  input  32  multiplier or divisor, two's complement.
REQ-006 Port: ctrl_MULT  input  1  single-cycle start pulse for a multiply.
REQ-007 Port: ctrl_DIV  input  1  single-cycle start pulse for a divide.
REQ-008 Port: data_result  output  32  product low word or quotient; registered.
REQ-009 Port: data_exception  output  1  overflow or divide-by-zero flag; registered.
REQ-010 Port: data_resultRDY  output  1  one-cycle completion strobe; registered.

Function
REQ-011 The block SHALL implement the states IDLE, MULT, DIV and DONE.
REQ-012 Start: operands SHALL be latched at the clock edge where ctrl_MULT or ctrl_DIV is sampled high (edge T); the operand inputs are don't-care after edge T.
REQ-013 Multiply SHALL use an iterative shift-add datapath, 1 bit per cycle, 32 iterations, with a 6-bit iteration counter.
REQ-014 Divide SHALL use an iterative restoring or non-restoring datapath on operand magnitudes, 1 quotient bit per cycle, 32 iterations, with the sign fixed up at the end.
REQ-015 Latency SHALL be fixed at 33 for both operations: data_resultRDY is high for exactly one cycle, in the cycle following edge T+33.
REQ-016 data_result, data_exception and data_resultRDY SHALL update together at edge T+33.
REQ-017 data_result and data_exception SHALL then hold until the next completion or reset.
REQ-018 Multiply result SHALL be bits [31:0] of the signed 64-bit product.
REQ-019 Multiply data_exception SHALL be 1 iff bits [63:31] of the product are not all equal.
REQ-020 Divide quotient SHALL be signed and truncated toward zero; the remainder is discarded.
REQ-021 Divide-by-zero (B = 0): data_result SHALL be 0 and data_exception 1, at the same 33-cycle latency.
REQ-022 Divide 0x80000000 / 0xFFFFFFFF: data_result SHALL be 0x80000000 and data_exception 1.
REQ-023 All other divides SHALL give data_exception 0.
REQ-024 Simultaneous ctrl_MULT and ctrl_DIV: multiply SHALL take priority and the divide request is dropped.
REQ-025 Start while busy (MULT, DIV or DONE state): the in-flight operation SHALL be aborted and no RDY issued for it.
REQ-026 After an abort, the new operation SHALL restart with latency 33 from that edge; data_result keeps its previous completed value meanwhile.
REQ-027 Start in the same cycle RDY is high SHALL be accepted, with no lost cycle.
REQ-028 A ctrl pulse held high for multiple cycles SHALL restart on each sampled-high edge.
REQ-029 Transitions: IDLE to MULT/DIV on start; MULT/DIV to DONE after 32 iterations; DONE to IDLE (or to MULT/DIV on a new start) after one cycle.

Reset
REQ-030 On reset sampled high: state SHALL go to IDLE, the counter SHALL clear, and data_result, data_exception and data_resultRDY SHALL be 0.
REQ-031 Reset SHALL take priority over ctrl_MULT and ctrl_DIV in the same cycle.
REQ-032 Reset mid-operation SHALL cancel the operation with no RDY ever issued for it.

Verification
REQ-033 Multiply -> RDY exactly 33 cycles after the start edge, with no early strobe:
- 7 x -3 -> data_result 0xFFFFFFEB, data_exception 0.
- 0x00010000 x 0x00010000 -> data_result 0x00000000, data_exception 1.
REQ-034 Divide:
- -7 / 2 -> data_result 0xFFFFFFFD, data_exception 0.
- 100 / 0 -> data_result 0, data_exception 1.
- 0x80000000 / -1 -> data_result 0x80000000, data_exception 1.
REQ-035 Priority and restart:
- ctrl_MULT and ctrl_DIV together with A=6, B=3 -> data_result 18 (multiply), not 2.
- Start 5x5, then 10 cycles later start 9/3 -> a single RDY 33 cycles after the second start, data_result 3; no RDY for 25.
REQ-036 Reset:
- Reset asserted 20 cycles into a multiply -> outputs 0 the next cycle, and no RDY within the following 40 cycles.
- Back-to-back: new start in the RDY cycle -> second RDY exactly 33 cycles later with the correct value.

Source files
------------

// File: rtl/multdiv_seq.sv
// Sequential 32-bit signed multiply / divide, 1 bit per cycle, fixed 33-cycle start-to-result latency.
// No backpressure: a new start always aborts any in-flight operation; data_resultRDY is a one-cycle strobe.
module multdiv_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic        op_div, op_div_n;
    logic        neg, neg_n;
    logic        div_zero, div_zero_n;
    logic        div_ovf, div_ovf_n;
    logic [31:0] opnd, opnd_n;
    // hi/lo: partial product and shifting multiplier, or partial remainder and quotient
    logic [32:0] hi, hi_n;
    logic [31:0] lo, lo_n;
    logic [31:0] result_n;
    logic        exception_n;
    logic        rdy_n;

    logic        start;
    logic [31:0] mag_a, mag_b;
    logic [32:0] add_sum;
    logic [32:0] rem_shift;
    logic [33:0] rem_diff;
    logic [63:0] prod_mag;
    logic [63:0] prod_signed;
    logic [31:0] quot_signed;

    function automatic logic [31:0] magnitude(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    assign start       = ctrl_MULT | ctrl_DIV;
    assign mag_a       = magnitude(data_operandA);
    assign mag_b       = magnitude(data_operandB);
    assign add_sum     = hi + {1'b0, (lo[0] ? opnd : 32'd0)};
    assign rem_shift   = {hi[31:0], lo[31]};
    assign rem_diff    = {1'b0, rem_shift} - {2'b00, opnd};
    assign prod_mag    = {hi[31:0], lo};
    assign prod_signed = neg ? (~prod_mag + 64'd1) : prod_mag;
    assign quot_signed = neg ? (~lo + 32'd1) : lo;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 6'd0;
            op_div         <= 1'b0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            opnd           <= 32'd0;
            hi             <= 33'd0;
            lo             <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            op_div         <= op_div_n;
            neg            <= neg_n;
            div_zero       <= div_zero_n;
            div_ovf        <= div_ovf_n;
            opnd           <= opnd_n;
            hi             <= hi_n;
            lo             <= lo_n;
            data_result    <= result_n;
            data_exception <= exception_n;
            data_resultRDY <= rdy_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        op_div_n    = op_div;
        neg_n       = neg;
        div_zero_n  = div_zero;
        div_ovf_n   = div_ovf;
        opnd_n      = opnd;
        hi_n        = hi;
        lo_n        = lo;
        result_n    = data_result;
        exception_n = data_exception;
        rdy_n       = 1'b0;

        if (start) begin
            // Multiply wins when both strobes arrive together
            op_div_n   = ~ctrl_MULT;
            neg_n      = data_operandA[31] ^ data_operandB[31];
            div_zero_n = (data_operandB == 32'd0);
            div_ovf_n  = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            opnd_n     = ctrl_MULT ? mag_a : mag_b;
            lo_n       = ctrl_MULT ? mag_b : mag_a;
            hi_n       = 33'd0;
            cnt_n      = 6'd0;
            state_n    = ctrl_MULT ? MULT : DIV;
        end else begin
            case (state)
                MULT: begin
                    hi_n  = {1'b0, add_sum[32:1]};
                    lo_n  = {add_sum[0], lo[31:1]};
                    cnt_n = cnt + 6'd1;
                    if (cnt == 6'd31) state_n = DONE;
                end
                DIV: begin
                    if (!rem_diff[33]) begin
                        hi_n = rem_diff[32:0];
                        lo_n = {lo[30:0], 1'b1};
                    end else begin
                        hi_n = rem_shift;
                        lo_n = {lo[30:0], 1'b0};
                    end
                    cnt_n = cnt + 6'd1;
                    if (cnt == 6'd31) state_n = DONE;
                end
                DONE: begin
                    rdy_n   = 1'b1;
                    state_n = IDLE;
                    if (!op_div) begin
                        result_n    = prod_signed[31:0];
                        exception_n = ~((&prod_signed[63:31]) | ~(|prod_signed[63:31]));
                    end else if (div_zero) begin
                        result_n    = 32'd0;
                        exception_n = 1'b1;
                    end else begin
                        result_n    = quot_signed;
                        exception_n = div_ovf;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule
